// File: rtl/axi_rr_pkg.sv
// Shared helpers for the round-robin response routers: width calculations
// and the port-index type used on the request/response return path.
package axi_rr_pkg;

  localparam int PORT_IDX_MAX_W = 8;

  typedef logic [PORT_IDX_MAX_W-1:0] port_idx_t;

  function automatic int idx_w(input int n_port);
    return (n_port > 1) ? $clog2(n_port) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/axi_rr_idx_fifo.sv
// Generic synchronous FIFO holding granted port indices in issue order.
// Push while full and pop while empty are ignored, so count stays in 0..DEPTH.
module axi_rr_idx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Pointers are power-of-two sized and wrap without explicit compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/axi_rr_resp_route.sv
// Steers R/B response beats back to the slave port that won arbitration,
// in grant order, using an index FIFO filled at each accepted grant.
module axi_rr_resp_route
  import axi_rr_pkg::*;
#(
  parameter int N_PORT = 4,
  parameter int DEPTH  = 8,
  parameter int IDX_W  = idx_w(N_PORT),
  parameter int CNT_W  = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  input  logic              req_gnt_i,
  input  logic [IDX_W-1:0]  req_idx_i,
  output logic              req_stall_o,
  input  logic              rsp_valid_i,
  input  logic              rsp_last_i,
  output logic              rsp_ready_o,
  output logic [N_PORT-1:0] rsp_valid_o,
  input  logic [N_PORT-1:0] rsp_ready_i,
  output logic [IDX_W-1:0]  rsp_sel_o,
  output logic [CNT_W-1:0]  outstanding_o,
  output logic              rsp_err_o
);

  logic             push;
  logic             pop;
  logic [IDX_W-1:0] head_idx;
  logic             full;
  logic             empty;
  logic             head_valid;

  assign push = req_valid_i & req_gnt_i & ~full;
  // Only the last beat retires the entry, keeping a burst on one port.
  assign pop  = rsp_valid_i & rsp_ready_o & rsp_last_i;

  axi_rr_idx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (IDX_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (req_idx_i),
    .rdata (head_idx),
    .count (outstanding_o),
    .full  (full),
    .empty (empty)
  );

  assign head_valid  = ~empty;
  assign req_stall_o = full;
  assign rsp_sel_o   = head_valid ? head_idx : '0;
  assign rsp_ready_o = head_valid & rsp_ready_i[rsp_sel_o];

  always_comb begin
    rsp_valid_o = '0;
    for (int k = 0; k < N_PORT; k++) begin
      rsp_valid_o[k] = rsp_valid_i & head_valid & (rsp_sel_o == IDX_W'(k));
    end
  end

  // A response with nothing tracked is a protocol error; held until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err_o <= 1'b0;
    end else if (rsp_valid_i & empty) begin
      rsp_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_rr_resp_route.sv
// Self-checking bench for axi_rr_resp_route: directed scenarios plus random
// traffic, compared against a queue-based model of the tracking order.
module tb_axi_rr_resp_route;

  logic       clk;
  logic       rst_n;
  logic       req_valid_i;
  logic       req_gnt_i;
  logic [1:0] req_idx_i;
  logic       req_stall_o;
  logic       rsp_valid_i;
  logic       rsp_last_i;
  logic       rsp_ready_o;
  logic [3:0] rsp_valid_o;
  logic [3:0] rsp_ready_i;
  logic [1:0] rsp_sel_o;
  logic [3:0] outstanding_o;
  logic       rsp_err_o;

  int total = 0;
  int bad   = 0;

  int q[$];
  bit m_err;

  axi_rr_resp_route #(.N_PORT(4), .DEPTH(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid_i   (req_valid_i),
    .req_gnt_i     (req_gnt_i),
    .req_idx_i     (req_idx_i),
    .req_stall_o   (req_stall_o),
    .rsp_valid_i   (rsp_valid_i),
    .rsp_last_i    (rsp_last_i),
    .rsp_ready_o   (rsp_ready_o),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_sel_o     (rsp_sel_o),
    .outstanding_o (outstanding_o),
    .rsp_err_o     (rsp_err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [3:0] exp_vld();
    return (q.size() != 0 && rsp_valid_i) ? 4'(1 << q[0]) : 4'b0000;
  endfunction

  function automatic logic exp_rdy();
    return (q.size() != 0) ? rsp_ready_i[q[0]] : 1'b0;
  endfunction

  function automatic logic [1:0] exp_sel();
    return (q.size() != 0) ? 2'(q[0]) : 2'd0;
  endfunction

  task automatic idle();
    req_valid_i = 0; req_gnt_i = 0; req_idx_i = 0;
    rsp_valid_i = 0; rsp_last_i = 0; rsp_ready_i = 0;
  endtask

  // Advance one clock; the model consumes the inputs seen at the edge.
  task automatic cycle();
    bit push_ok, pop_ok;
    @(posedge clk);
    if (rst_n) begin
      push_ok = req_valid_i && req_gnt_i && (q.size() < 8);
      pop_ok  = rsp_valid_i && (q.size() != 0) && rsp_ready_i[q[0]] && rsp_last_i;
      if (rsp_valid_i && q.size() == 0) m_err = 1;
      if (pop_ok)  void'(q.pop_front());
      if (push_ok) q.push_back(int'(req_idx_i));
    end
    #1;
  endtask

  task automatic push_one(input logic [1:0] idx);
    idle();
    req_valid_i = 1; req_gnt_i = 1; req_idx_i = idx;
    cycle();
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    q.delete(); m_err = 0;
    cycle(); cycle();
    total++; if (outstanding_o !== 4'd0) begin bad++; $display("FAIL reset_cnt act=%0d exp=0", outstanding_o); end
    total++; if (req_stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall act=%b exp=0", req_stall_o); end
    total++; if (rsp_ready_o !== 1'b0) begin bad++; $display("FAIL reset_rdy act=%b exp=0", rsp_ready_o); end
    total++; if (rsp_valid_o !== 4'b0) begin bad++; $display("FAIL reset_vld act=%b exp=0000", rsp_valid_o); end
    total++; if (rsp_sel_o !== 2'd0) begin bad++; $display("FAIL reset_sel act=%0d exp=0", rsp_sel_o); end
    total++; if (rsp_err_o !== 1'b0) begin bad++; $display("FAIL reset_err act=%b exp=0", rsp_err_o); end
    rst_n = 1;
    cycle();
  endtask

  task automatic test_b_order();
    logic [3:0] exp_onehot [3];
    exp_onehot[0] = 4'b0100; exp_onehot[1] = 4'b0001; exp_onehot[2] = 4'b1000;
    push_one(2); push_one(0); push_one(3);
    total++; if (outstanding_o !== 4'd3) begin bad++; $display("FAIL b_cnt3 act=%0d exp=3", outstanding_o); end
    for (int i = 0; i < 3; i++) begin
      rsp_valid_i = 1; rsp_last_i = 1; rsp_ready_i = 4'b1111;
      #1;
      total++; if (rsp_valid_o !== exp_onehot[i]) begin bad++; $display("FAIL b_vld%0d act=%b exp=%b", i, rsp_valid_o, exp_onehot[i]); end
      total++; if (rsp_ready_o !== 1'b1) begin bad++; $display("FAIL b_rdy%0d act=%b exp=1", i, rsp_ready_o); end
      cycle();
      total++; if (outstanding_o !== 4'(2 - i)) begin bad++; $display("FAIL b_cnt%0d act=%0d exp=%0d", i, outstanding_o, 2 - i); end
    end
    idle();
  endtask

  task automatic test_r_burst();
    logic [4:0] pat;
    int beats;
    pat = 5'b11101;  // bit i = ready of port 1 in cycle i: 1,0,1,1,1
    beats = 0;
    push_one(1);
    for (int i = 0; i < 5; i++) begin
      rsp_valid_i = 1;
      rsp_ready_i = 4'($urandom);
      rsp_ready_i[1] = pat[i];
      rsp_last_i = (beats == 3);
      #1;
      total++; if (rsp_valid_o !== 4'b0010) begin bad++; $display("FAIL r_vld%0d act=%b exp=0010", i, rsp_valid_o); end
      total++; if (rsp_ready_o !== pat[i]) begin bad++; $display("FAIL r_rdy%0d act=%b exp=%b", i, rsp_ready_o, pat[i]); end
      total++; if (outstanding_o !== 4'd1) begin bad++; $display("FAIL r_hold%0d act=%0d exp=1", i, outstanding_o); end
      cycle();
      if (pat[i]) beats++;
    end
    idle(); #1;
    total++; if (outstanding_o !== 4'd0) begin bad++; $display("FAIL r_pop act=%0d exp=0", outstanding_o); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) push_one(2'($urandom));
    total++; if (req_stall_o !== 1'b1) begin bad++; $display("FAIL full_stall act=%b exp=1", req_stall_o); end
    total++; if (outstanding_o !== 4'd8) begin bad++; $display("FAIL full_cnt act=%0d exp=8", outstanding_o); end
    push_one(2'($urandom));
    total++; if (outstanding_o !== 4'd8) begin bad++; $display("FAIL full_ign act=%0d exp=8", outstanding_o); end
    req_valid_i = 1; req_gnt_i = 1; req_idx_i = 2'($urandom);
    rsp_valid_i = 1; rsp_last_i = 1; rsp_ready_i = 4'b1111;
    cycle(); idle();
    total++; if (outstanding_o !== 4'd7) begin bad++; $display("FAIL full_pp act=%0d exp=7", outstanding_o); end
    total++; if (req_stall_o !== 1'b0) begin bad++; $display("FAIL full_unstall act=%b exp=0", req_stall_o); end
    push_one(2'($urandom));
    total++; if (outstanding_o !== 4'd8) begin bad++; $display("FAIL full_refill act=%0d exp=8", outstanding_o); end
    for (int i = 0; i < 8; i++) begin
      rsp_valid_i = 1; rsp_last_i = 1; rsp_ready_i = 4'b1111;
      #1;
      total++; if (rsp_sel_o !== exp_sel()) begin bad++; $display("FAIL drain_sel%0d act=%0d exp=%0d", i, rsp_sel_o, exp_sel()); end
      cycle();
    end
    idle(); #1;
    total++; if (outstanding_o !== 4'd0) begin bad++; $display("FAIL drain_cnt act=%0d exp=0", outstanding_o); end
  endtask

  task automatic test_stream();
    push_one(3); push_one(1); push_one(2);
    for (int i = 0; i < 40; i++) begin
      req_valid_i = 1; req_gnt_i = 1; req_idx_i = 2'(i % 4);
      rsp_valid_i = 1; rsp_last_i = 1; rsp_ready_i = 4'b1111;
      #1;
      total++; if (rsp_valid_o !== exp_vld()) begin bad++; $display("FAIL stream_vld%0d act=%b exp=%b", i, rsp_valid_o, exp_vld()); end
      cycle();
      total++; if (outstanding_o !== 4'd3) begin bad++; $display("FAIL stream_cnt%0d act=%0d exp=3", i, outstanding_o); end
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      rsp_valid_i = 1; rsp_last_i = 1; rsp_ready_i = 4'b1111;
      #1;
      total++; if (rsp_sel_o !== exp_sel()) begin bad++; $display("FAIL stream_tail%0d act=%0d exp=%0d", i, rsp_sel_o, exp_sel()); end
      cycle();
    end
    idle();
  endtask

  task automatic test_empty_err();
    #1;
    total++; if (rsp_err_o !== 1'b0) begin bad++; $display("FAIL err_pre act=%b exp=0", rsp_err_o); end
    rsp_valid_i = 1; rsp_last_i = 1; rsp_ready_i = 4'b1111;
    #1;
    total++; if (rsp_ready_o !== 1'b0) begin bad++; $display("FAIL err_rdy act=%b exp=0", rsp_ready_o); end
    total++; if (rsp_valid_o !== 4'b0) begin bad++; $display("FAIL err_vld act=%b exp=0000", rsp_valid_o); end
    cycle(); idle();
    for (int i = 0; i < 3; i++) begin
      cycle();
      total++; if (rsp_err_o !== 1'b1) begin bad++; $display("FAIL err_sticky%0d act=%b exp=1", i, rsp_err_o); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      req_valid_i = 1'($urandom); req_gnt_i = ($urandom_range(0, 3) != 0);
      req_idx_i = 2'($urandom);
      rsp_valid_i = 1'($urandom); rsp_last_i = 1'($urandom);
      rsp_ready_i = 4'($urandom);
      #1;
      total++; if (rsp_valid_o !== exp_vld()) begin bad++; $display("FAIL rnd_vld%0d act=%b exp=%b", i, rsp_valid_o, exp_vld()); end
      total++; if (rsp_ready_o !== exp_rdy()) begin bad++; $display("FAIL rnd_rdy%0d act=%b exp=%b", i, rsp_ready_o, exp_rdy()); end
      total++; if (rsp_sel_o !== exp_sel()) begin bad++; $display("FAIL rnd_sel%0d act=%0d exp=%0d", i, rsp_sel_o, exp_sel()); end
      total++; if (outstanding_o !== 4'(q.size())) begin bad++; $display("FAIL rnd_cnt%0d act=%0d exp=%0d", i, outstanding_o, q.size()); end
      total++; if (req_stall_o !== (q.size() == 8)) begin bad++; $display("FAIL rnd_stall%0d act=%b exp=%b", i, req_stall_o, q.size() == 8); end
      total++; if (rsp_err_o !== m_err) begin bad++; $display("FAIL rnd_err%0d act=%b exp=%b", i, rsp_err_o, m_err); end
      cycle();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    while (q.size() != 0) begin
      rsp_valid_i = 1; rsp_last_i = 1; rsp_ready_i = 4'b1111;
      cycle();
    end
    idle();
    for (int i = 0; i < 5; i++) push_one(2'($urandom));
    total++; if (outstanding_o !== 4'd5) begin bad++; $display("FAIL mid_cnt act=%0d exp=5", outstanding_o); end
    rsp_valid_i = 1; rsp_last_i = 0; rsp_ready_i = 4'b1111;
    cycle();
    #2 rst_n = 0;
    q.delete(); m_err = 0;
    #1;
    total++; if (outstanding_o !== 4'd0) begin bad++; $display("FAIL mid_rcnt act=%0d exp=0", outstanding_o); end
    total++; if (rsp_valid_o !== 4'b0) begin bad++; $display("FAIL mid_rvld act=%b exp=0000", rsp_valid_o); end
    total++; if (rsp_ready_o !== 1'b0) begin bad++; $display("FAIL mid_rrdy act=%b exp=0", rsp_ready_o); end
    total++; if (rsp_err_o !== 1'b0) begin bad++; $display("FAIL mid_rerr act=%b exp=0", rsp_err_o); end
    total++; if (req_stall_o !== 1'b0) begin bad++; $display("FAIL mid_rstall act=%b exp=0", req_stall_o); end
    total++; if (rsp_sel_o !== 2'd0) begin bad++; $display("FAIL mid_rsel act=%0d exp=0", rsp_sel_o); end
    idle();
    cycle();
    rst_n = 1;
    cycle();
    push_one(3);
    rsp_valid_i = 1; rsp_last_i = 1; rsp_ready_i = 4'b1111;
    #1;
    total++; if (rsp_valid_o !== 4'b1000) begin bad++; $display("FAIL post_vld act=%b exp=1000", rsp_valid_o); end
    total++; if (rsp_sel_o !== 2'd3) begin bad++; $display("FAIL post_sel act=%0d exp=3", rsp_sel_o); end
    cycle(); idle();
    total++; if (outstanding_o !== 4'd0) begin bad++; $display("FAIL post_cnt act=%0d exp=0", outstanding_o); end
  endtask

  initial begin
    rst_n = 0;
    idle();
    test_reset();
    test_b_order();
    test_r_burst();
    test_full();
    test_stream();
    test_empty_err();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
